// File: rtl/lan_bus_ctrl.sv
// Avalon-MM slave that runs timed CS#/IOR#/IOW#/CMD bus cycles on a DM9000A-style LAN chip.
// Every lan_* pin and readdata come from flops, loaded from the next-state values.
module lan_bus_ctrl #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        waitrequest,
  input  logic        cs_enable,
  output logic        lan_cs_n,
  output logic        lan_ior_n,
  output logic        lan_iow_n,
  output logic        lan_cmd,
  output logic [15:0] lan_data_out,
  output logic        lan_data_oe,
  input  logic [15:0] lan_data_in
);

  // state  | meaning
  // IDLE   | bus released, waiting for a request
  // SETUP  | CS#/CMD/data valid, strobe high
  // STROBE | IOR# or IOW# low
  // HOLD   | strobe high, CS#/CMD/data still held
  // DONE   | bus released, waitrequest low for one cycle
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC);

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic        addr_q, addr_nx;
  logic        wr_q, wr_nx;
  logic [15:0] wdata_q, wdata_nx;
  logic [15:0] rdata_nx;
  logic        request;
  logic        active_nx;
  logic        cs_n_nx, ior_n_nx, iow_n_nx, cmd_nx, oe_nx;
  logic [15:0] dout_nx;

  assign request     = chipselect & (read | write);
  assign waitrequest = request & (state != DONE);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    addr_nx  = addr_q;
    wr_nx    = wr_q;
    wdata_nx = wdata_q;
    rdata_nx = readdata;
    case (state)
      IDLE: begin
        if (request) begin
          addr_nx  = address;
          wr_nx    = write;
          wdata_nx = writedata;
          if (cs_enable) begin
            state_nx = SETUP;
            cnt_nx   = SETUP_LD;
          end else begin
            state_nx = DONE;
            rdata_nx = '0;
          end
        end
      end
      SETUP: begin
        if (cnt == 8'd1) begin
          state_nx = STROBE;
          cnt_nx   = STROBE_LD;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      STROBE: begin
        if (cnt == 8'd1) begin
          if (!wr_q) rdata_nx = lan_data_in;
          state_nx = HOLD;
          cnt_nx   = HOLD_LD;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      HOLD: begin
        if (cnt == 8'd1) state_nx = DONE;
        else             cnt_nx   = cnt - 8'd1;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // cmd and data read 0 while the bus is released so a bypassed access moves no pin
    active_nx = (state_nx == SETUP) || (state_nx == STROBE) || (state_nx == HOLD);
    cs_n_nx   = ~active_nx;
    cmd_nx    = active_nx & addr_nx;
    oe_nx     = active_nx & wr_nx;
    dout_nx   = oe_nx ? wdata_nx : 16'h0000;
    iow_n_nx  = ~((state_nx == STROBE) & wr_nx);
    ior_n_nx  = ~((state_nx == STROBE) & ~wr_nx);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_q       <= 1'b0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      readdata     <= '0;
      lan_cs_n     <= 1'b1;
      lan_ior_n    <= 1'b1;
      lan_iow_n    <= 1'b1;
      lan_cmd      <= 1'b0;
      lan_data_out <= '0;
      lan_data_oe  <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      addr_q       <= addr_nx;
      wr_q         <= wr_nx;
      wdata_q      <= wdata_nx;
      readdata     <= rdata_nx;
      lan_cs_n     <= cs_n_nx;
      lan_ior_n    <= ior_n_nx;
      lan_iow_n    <= iow_n_nx;
      lan_cmd      <= cmd_nx;
      lan_data_out <= dout_nx;
      lan_data_oe  <= oe_nx;
    end
  end

endmodule
